// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding.
package serial_add_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell shared by the serial adder datapath.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic A,
  output logic cout
);

  assign A    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one fulladder over WIDTH cycles, LSB first,
// behind a start/done handshake. {cout,sum} = a + b + cin.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;

  fulladder u_fa (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .cin  (carry_q),
    .A    (fa_sum),
    .cout (fa_cout)
  );

  // A request is only honoured when no addition is in flight.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= S_RUN;
        sa_q    <= a;
        sb_q    <= b;
        carry_q <= cin;
        cnt_q   <= '0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          S_RUN: begin
            sa_q    <= sa_q >> 1;
            sb_q    <= sb_q >> 1;
            carry_q <= fa_cout;
            // New bits enter at the MSB so bit i settles at sum[i] after WIDTH shifts.
            sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
              cout_q  <= fa_cout;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
